// File: rtl/input_conditioner_pkg.sv
// Shared types and default sizing for the switch/button input conditioner.
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b10,
    WAIT_LO   = 2'b11
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DB_CYCLES   = 4;

endpackage

// File: rtl/input_conditioner_sync_chain.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module sync_chain
  import input_conditioner_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) sr <= '0;
    else       sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronize, debounce and edge-detect a raw input; outputs are registered
// so d_out/en_out can feed a downstream enabled flop directly.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DB_CYCLES   = DEF_DB_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic d_out,
  output logic en_out,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync_q;
  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          d_nxt;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (din),
    .q     (sync_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= STABLE_LO;
      cnt    <= '0;
      d_out  <= 1'b0;
      en_out <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      d_out  <= d_nxt;
      en_out <= d_nxt ^ d_out;
      rise   <= d_nxt & ~d_out;
      fall   <= ~d_nxt & d_out;
    end
  end

  // Counter holds the number of consecutive cycles the new level has been seen.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    case (state)
      STABLE_LO: if (sync_q) begin
        state_nxt = WAIT_HI;
        cnt_nxt   = CW'(1);
      end
      WAIT_HI: begin
        if (!sync_q)               state_nxt = STABLE_LO;
        else if (cnt == CNT_LAST)  state_nxt = STABLE_HI;
        else                       cnt_nxt   = cnt + CW'(1);
      end
      STABLE_HI: if (!sync_q) begin
        state_nxt = WAIT_LO;
        cnt_nxt   = CW'(1);
      end
      WAIT_LO: begin
        if (sync_q)                state_nxt = STABLE_HI;
        else if (cnt == CNT_LAST)  state_nxt = STABLE_LO;
        else                       cnt_nxt   = cnt + CW'(1);
      end
      default: state_nxt = STABLE_LO;
    endcase
    d_nxt = (state_nxt == STABLE_HI) || (state_nxt == WAIT_LO);
  end

endmodule

// File: doc/input_conditioner.md
INPUT_CONDITIONER -- requirements
Module: input_conditioner

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops (legal 2..4).
REQ-002 Parameter DB_CYCLES, default 4, consecutive stable cycles needed to accept a level change (legal 2..65535).
REQ-003 Port clk  input  1  clock; all state updates on rising edge.
REQ-004 Port reset  input  1  reset, synchronous, active-high.
REQ-005 Port din  input  1  raw asynchronous input (switch/button).
REQ-006 Port d_out  output  1  debounced level; drives downstream flop data input.
REQ-007 Port en_out  output  1  one-cycle pulse on every accepted change; drives downstream flop enable.
REQ-008 Port rise  output  1  one-cycle pulse on accepted 0->1 change.
REQ-009 Port fall  output  1  one-cycle pulse on accepted 1->0 change.

Function
REQ-010 din SHALL pass through a SYNC_STAGES-deep flop chain; the last stage (sync_q) is the only internal use of din.
REQ-011 FSM states SHALL be STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO.
REQ-012 STABLE_LO: sync_q=1 -> WAIT_HI, counter loads 1; else hold, counter 0.
REQ-013 WAIT_HI: sync_q=0 -> STABLE_LO, counter 0 (glitch rejected, no pulse); sync_q=1 with counter=DB_CYCLES-1 -> STABLE_HI; else counter +1.
REQ-014 STABLE_HI/WAIT_LO SHALL mirror REQ-012/013 with levels inverted.
REQ-015 d_out SHALL be 1 exactly in STABLE_HI and WAIT_LO, and SHALL be registered, not decoded combinationally.
REQ-016 Latency: if sync_q first shows a new value after edge k and holds, d_out SHALL change after edge k+DB_CYCLES; with din changing before edge 1, after edge SYNC_STAGES+DB_CYCLES.
REQ-017 en_out SHALL be high for exactly the one cycle following the edge at which d_out changes; rise or fall (per direction) SHALL be high in that same cycle; rise and fall SHALL never be high together.
REQ-018 Counter width SHALL be $clog2(DB_CYCLES+1); counter SHALL never exceed DB_CYCLES-1 and SHALL not wrap.
REQ-019 A bounce that returns to the old level before acceptance SHALL produce no pulse and no d_out change; the next opposite transition restarts counting from 1.
REQ-020 Minimum spacing between two en_out pulses SHALL be DB_CYCLES cycles.

Reset
REQ-021 reset SHALL clear all synchronizer flops, counter, and outputs to 0 and force STABLE_LO, overriding all other activity including a WAIT state in progress.
REQ-022 Outputs during and in the cycle after reset: d_out=0, en_out=0, rise=0, fall=0.
REQ-023 If din is 1 when reset deasserts, the block SHALL treat it as a normal 0->1 change: d_out rises after REQ-016 latency with one rise/en_out pulse.

Structure
REQ-024 Package input_conditioner_pkg SHALL hold the state typedef (2-bit enum) and default SYNC_STAGES/DB_CYCLES constants.
REQ-025 The synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES, ports clk, reset, d, q).
REQ-026 No other sub-modules; FSM, counter, and pulse registers live in input_conditioner.

Verification (SYNC_STAGES=2, DB_CYCLES=4, edges counted from first edge after din changes = edge 1)
REQ-027 Clean rise: din 0->1 held -> d_out=1 after edge 6; en_out and rise high cycle 6->7 only; fall stays 0.
REQ-028 Glitch: din high for 3 cycles then low -> d_out stays 0, no en_out/rise/fall pulse, FSM returns to STABLE_LO.
REQ-029 Bounce: din 1,0,1,1,1,1 (one cycle each then held) -> single rise pulse, timed from the final 0->1 edge.
REQ-030 Fall: from d_out=1, din 1->0 held -> d_out=0 after edge 6; en_out and fall high one cycle; rise stays 0.
REQ-031 Reset mid-WAIT_HI (counter=2) -> after that edge state STABLE_LO, counter 0, all outputs 0, no pulse; din still 1 -> rise after full latency measured from reset deassertion.
REQ-032 Downstream pairing: d_out/en_out into an enabled D flop -> flop q tracks d_out one cycle later and changes only on en_out cycles.
